// File: rtl/feature_fwft_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | feature_fwft_fifo                                                          |
// | First-word-fall-through FIFO for multi-channel feature words.              |
// | (DEPTH-1)-entry circular RAM feeding one registered output stage.          |
// | Optional macro FEATURE_FWFT_ERR_FLAGS_EN enables sticky overflow/underflow.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module feature_fwft_fifo #(
  parameter int DATA_W = 8,
  parameter int CH     = 1,
  parameter int DEPTH  = 16,
  parameter int AF_TH  = DEPTH - 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [CH*DATA_W-1:0]      in_feature,
  input  logic                      rd_en,
  output logic                      feature_valid,
  output logic [CH*DATA_W-1:0]      out_feature,
  output logic                      full,
  output logic                      almost_full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int c_w   = CH * DATA_W;
  localparam int c_cw  = $clog2(DEPTH) + 1;
  localparam int c_pw  = $clog2(DEPTH);
  localparam int c_ram = DEPTH - 1;

  localparam logic [c_cw-1:0] c_depth    = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_af       = c_cw'(AF_TH);
  localparam logic [c_cw-1:0] c_one      = c_cw'(1);
  localparam logic [c_pw-1:0] c_ptr_last = c_pw'(c_ram - 1);

  logic [c_w-1:0]  r_ram [c_ram];
  logic [c_pw-1:0] r_wr_ptr;
  logic [c_pw-1:0] r_rd_ptr;
  logic [c_w-1:0]  r_out;
  logic            r_valid;
  logic [c_cw-1:0] r_count;
  logic            r_full;
  logic            r_af;
  logic            r_armed;

  logic            w_wr_acc;
  logic            w_rd_acc;
  logic            w_ram_empty;
  logic            w_load;
  logic            w_ram_wr;
  logic            w_ram_rd;
  logic [c_cw-1:0] w_count_nxt;

  function automatic logic [c_pw-1:0] ptr_inc(input logic [c_pw-1:0] p);
    return (p == c_ptr_last) ? '0 : p + 1'b1;
  endfunction

  // r_armed masks the handshakes on the first edge after reset release.
  assign w_wr_acc    = r_armed & wr_en & ~r_full;
  assign w_rd_acc    = r_armed & rd_en & r_valid;
  assign w_ram_empty = (r_count == {{(c_cw-1){1'b0}}, r_valid});
  assign w_load      = w_rd_acc | ~r_valid;
  assign w_ram_rd    = w_load & ~w_ram_empty;
  assign w_ram_wr    = w_wr_acc & ~(w_load & w_ram_empty);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + c_one;
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_nxt = r_count - c_one;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      r_ram[r_wr_ptr] <= in_feature;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed  <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_out    <= '0;
      r_valid  <= 1'b0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_af     <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_depth);
      r_af    <= (w_count_nxt >= c_af);
      if (w_ram_wr) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      // Output stage refills from RAM first, else straight from the write port.
      if (w_ram_rd) begin
        r_out    <= r_ram[r_rd_ptr];
        r_rd_ptr <= ptr_inc(r_rd_ptr);
        r_valid  <= 1'b1;
      end else if (w_load && w_wr_acc) begin
        r_out   <= in_feature;
        r_valid <= 1'b1;
      end else if (w_rd_acc) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef FEATURE_FWFT_ERR_FLAGS_EN
  logic r_ovf;
  logic r_unf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | (r_armed & wr_en & r_full);
      r_unf <= r_unf | (r_armed & rd_en & ~r_valid);
    end
  end

  assign overflow  = r_ovf;
  assign underflow = r_unf;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign feature_valid = r_valid;
  assign out_feature   = r_out;
  assign full          = r_full;
  assign almost_full   = r_af;
  assign count         = r_count;

endmodule
`default_nettype wire

// File: doc/feature_fwft_fifo.md
FEATURE_FWFT_FIFO -- requirements
Module: feature_fwft_fifo

Interface
REQ-001 Parameter DATA_W, default 8: bits per feature sample.
REQ-002 Parameter CH, default 1: parallel channels per word, all moving under one handshake.
REQ-003 Parameter DEPTH, default 16: total word capacity, output register included; power of two, minimum 4.
REQ-004 Parameter AF_TH, default DEPTH-2: count at or above which almost_full asserts; range 1..DEPTH.
REQ-005 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset; assertion is immediate, release is synchronous to clk.
REQ-007 Port wr_en, input, 1: write request for in_feature.
REQ-008 Port in_feature, input, CH*DATA_W: write word; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 Port rd_en, input, 1: consumes the word on out_feature when feature_valid is high.
REQ-010 Port feature_valid, output, 1: out_feature holds the head word.
REQ-011 Port out_feature, output, CH*DATA_W: head word, first-word-fall-through, registered.
REQ-012 Port full, output, 1: count equals DEPTH.
REQ-013 Port almost_full, output, 1: count is at least AF_TH.
REQ-014 Port count, output, $clog2(DEPTH)+1: words held, output register included.
REQ-015 Ports overflow and underflow, outputs, 1 each: sticky error flags (see Configuration).

Function
REQ-016 Storage: (DEPTH-1)-entry circular RAM plus one output register; read and write pointers wrap modulo DEPTH-1; no bubble on wrap.
REQ-017 Write accepted when wr_en=1 and full=0; wr_en=1 with full=1 drops the word, with no state change, even if rd_en=1 in the same cycle.
REQ-018 Read accepted when rd_en=1 and feature_valid=1; rd_en=1 with feature_valid=0 is ignored.
REQ-019 Write to an empty FIFO: word bypasses the RAM into the output register; feature_valid=1 and out_feature valid in the next cycle (1-cycle latency).
REQ-020 Accepted read with RAM non-empty: next word loads into the output register the next cycle; feature_valid stays 1 (back-to-back reads sustain 1 word/clk).
REQ-021 Accepted read with RAM empty and a write in the same cycle: the written word loads into the output register; feature_valid stays 1.
REQ-022 Accepted read with RAM empty and no write: feature_valid=0 next cycle; out_feature holds its last value.
REQ-023 out_feature SHALL NOT change while feature_valid=1 and rd_en=0.
REQ-024 count: +1 on an accepted write only, -1 on an accepted read only, unchanged on both or neither; never exceeds DEPTH, never goes below 0.
REQ-025 full and almost_full are registered and consistent with count in the same cycle.
REQ-026 Channels are treated identically; no per-channel reordering or masking.

Reset
REQ-027 While rst=0: count=0, pointers=0, feature_valid=0, full=0, almost_full=0, out_feature=0, overflow=0, underflow=0.
REQ-028 Reset asserted mid-stream discards all contents immediately; the first write after release follows REQ-019.
REQ-029 wr_en and rd_en are ignored during reset and on the first edge of release.

Configuration
REQ-030 Macro FEATURE_FWFT_ERR_FLAGS_EN defined: overflow sets on a dropped write (REQ-017) and underflow sets on an ignored read (REQ-018); both hold until reset.
REQ-031 Macro FEATURE_FWFT_ERR_FLAGS_EN undefined: overflow and underflow are tied to 0, no flag logic is synthesised, and all other behaviour is unchanged.

Verification
REQ-032 Test: DATA_W=8, CH=1, DEPTH=16; one write of 8'h00 to an empty FIFO -> next cycle feature_valid=1, out_feature=8'h00, count=1.
REQ-033 Test: continuous writes of an incrementing 8-bit pattern with rd_en=0 -> full=1 at count=16, almost_full=1 from count=14; 17th write dropped; overflow=1 when the macro is defined.
REQ-034 Test: from full, rd_en=1 for 16 cycles -> out_feature reads 00..0F with no gaps, then feature_valid=0 and count=0; one further rd_en gives underflow=1 (macro defined).
REQ-035 Test: rd_en=1 continuously, wr_en=1 continuously, 4*256 incrementing words -> output sequence matches input with wrap FF->00, count stays at or below 1, no drops.
REQ-036 Test: CH=4, DATA_W=8; write 32'h04030201 -> out_feature=32'h04030201; apply rd_en in bursts of 5 cycles every 10 cycles against continuous writes -> no loss while full=0, order preserved.
REQ-037 Test: assert rst mid-burst with count=9 -> count, feature_valid and flags go to 0 immediately, without waiting for a clock edge; first post-release write gives 1-cycle latency.
